// File: rtl/zeroriscy_d_pkg.sv
// Shared types, geometry and lane helpers for the zero-riscy data SRAM bridge.
package zeroriscy_d_pkg;

  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned WORD_BITS  = 32;
  localparam int unsigned LINE_BITS  = 256;
  localparam int unsigned LINE_IDX_W = 12;
  localparam int unsigned WORD_IDX_W = 3;
  localparam int unsigned BE_W       = 4;

  typedef enum logic {
    IDLE,
    FILL
  } state_e;

  // Word 0 sits in the most significant lane of the SRAM line.
  function automatic int unsigned lane_lsb(input logic [WORD_IDX_W-1:0] k);
    return WORD_BITS * (LINE_WORDS - 1 - 32'(k));
  endfunction

  function automatic logic [WORD_BITS-1:0] line_lane(input logic [LINE_BITS-1:0] line,
                                                     input logic [WORD_IDX_W-1:0] k);
    return line[lane_lsb(k) +: WORD_BITS];
  endfunction

endpackage

// File: rtl/zeroriscy_d_linebuf.sv
// One-line read buffer: full-line load, byte-masked word write, tag compare, word read.
module zeroriscy_d_linebuf
  import zeroriscy_d_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en_i,
  input  logic [LINE_BITS-1:0]  load_line_i,
  input  logic [LINE_IDX_W-1:0] load_tag_i,
  input  logic                  wr_en_i,
  input  logic [WORD_IDX_W-1:0] wr_word_i,
  input  logic [BE_W-1:0]       wr_be_i,
  input  logic [WORD_BITS-1:0]  wr_data_i,
  input  logic [LINE_IDX_W-1:0] lookup_tag_i,
  input  logic [WORD_IDX_W-1:0] rd_word_i,
  output logic                  hit_c,
  output logic [WORD_BITS-1:0]  rd_data_c
);

  logic [LINE_BITS-1:0]  data_q, data_d;
  logic [LINE_IDX_W-1:0] tag_q, tag_d;
  logic                  valid_q, valid_d;

  assign hit_c     = valid_q && (tag_q == lookup_tag_i);
  assign rd_data_c = line_lane(data_q, rd_word_i);

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (load_en_i) begin
      data_d  = load_line_i;
      tag_d   = load_tag_i;
      valid_d = 1'b1;
    end else if (wr_en_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (wr_be_i[b]) data_d[lane_lsb(wr_word_i) + 8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/zeroriscy_d_sram_ctrl.sv
// LSU data port to 8-word-wide data SRAM bridge with a single-line read buffer.
module zeroriscy_d_sram_ctrl
  import zeroriscy_d_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [BE_W-1:0]       data_be_i,
  input  logic [WORD_BITS-1:0]  data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [WORD_BITS-1:0]  data_rdata_o,
  output logic                  data_err_o,
  output logic [LINE_IDX_W-1:0] sram_addr_o,
  output logic [LINE_WORDS-1:0] sram_cs_o,
  output logic                  sram_we_o,
  output logic [BE_W-1:0]       sram_be_o,
  output logic [WORD_BITS-1:0]  sram_din_o,
  input  logic [LINE_BITS-1:0]  sram_dout_i
);

  state_e                state_q, state_d;
  logic [LINE_IDX_W-1:0] fill_tag_q, fill_tag_d;
  logic [WORD_IDX_W-1:0] fill_word_q, fill_word_d;
  logic                  rvalid_q, rvalid_d;
  logic [WORD_BITS-1:0]  rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  in_range;
  logic [LINE_IDX_W-1:0] line_idx;
  logic [WORD_IDX_W-1:0] word_idx;
  logic                  buf_load, buf_wr, buf_hit;
  logic [WORD_BITS-1:0]  buf_word;
  logic                  unused_addr_lsb;

  assign in_range        = (data_addr_i[31:17] == BASE_ADDR[31:17]);
  assign line_idx        = data_addr_i[16:5];
  assign word_idx        = data_addr_i[4:2];
  assign unused_addr_lsb = ^data_addr_i[1:0];

  // Reset gates the grant so nothing reaches the SRAM while rst_n is low.
  assign data_gnt_o = rst_n && (state_q == IDLE) && data_req_i;

  zeroriscy_d_linebuf u_linebuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en_i    (buf_load),
    .load_line_i  (sram_dout_i),
    .load_tag_i   (fill_tag_q),
    .wr_en_i      (buf_wr),
    .wr_word_i    (word_idx),
    .wr_be_i      (data_be_i),
    .wr_data_i    (data_wdata_i),
    .lookup_tag_i (line_idx),
    .rd_word_i    (word_idx),
    .hit_c        (buf_hit),
    .rd_data_c    (buf_word)
  );

  always_comb begin
    state_d     = state_q;
    fill_tag_d  = fill_tag_q;
    fill_word_d = fill_word_q;
    rvalid_d    = 1'b0;
    rdata_d     = '0;
    err_d       = 1'b0;
    sram_addr_o = '0;
    sram_cs_o   = '0;
    sram_we_o   = 1'b0;
    sram_be_o   = '0;
    sram_din_o  = '0;
    buf_load    = 1'b0;
    buf_wr      = 1'b0;
    unique case (state_q)
      FILL: begin
        buf_load = 1'b1;
        rvalid_d = 1'b1;
        rdata_d  = line_lane(sram_dout_i, fill_word_q);
        state_d  = IDLE;
      end
      default: begin
        if (data_gnt_o) begin
          if (!in_range) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else if (data_we_i) begin
            // Write-through: SRAM always written, buffer merged only on a hit.
            sram_addr_o = line_idx;
            sram_cs_o   = LINE_WORDS'(1'b1) << word_idx;
            sram_we_o   = 1'b1;
            sram_be_o   = data_be_i;
            sram_din_o  = data_wdata_i;
            buf_wr      = buf_hit;
            rvalid_d    = 1'b1;
          end else if (buf_hit) begin
            rvalid_d = 1'b1;
            rdata_d  = buf_word;
          end else begin
            sram_addr_o = line_idx;
            sram_cs_o   = '1;
            fill_tag_d  = line_idx;
            fill_word_d = word_idx;
            state_d     = FILL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_tag_q  <= '0;
      fill_word_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_tag_q  <= fill_tag_d;
      fill_word_q <= fill_word_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: doc/zeroriscy_d_sram_ctrl.md
# zeroriscy_d_sram_ctrl

Bridge between the zero-riscy LSU data port and the 128 KB, 8-word-wide data SRAM (`zeroriscy_d_sram`). It decodes LSU byte addresses into the SRAM's line address and one-hot word chip-selects, and issues single-word writes. On a read miss it fetches a whole 256-bit line into a local line buffer, so later reads to the same line complete without touching the SRAM.

## Interface
- `BASE_ADDR`, default 32'h0002_0000: base of the 128 KB data window. Must be 128 KB aligned.
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `data_req_i`  in  1  LSU request
- `data_gnt_o`  out  1  request accepted this cycle; combinational from state and `data_req_i`
- `data_addr_i`  in  32  byte address
- `data_we_i`  in  1  1 = write
- `data_be_i`  in  4  byte enables
- `data_wdata_i`  in  32  write data
- `data_rvalid_o`  out  1  response valid, registered
- `data_rdata_o`  out  32  read data, registered; 0 for writes and errors
- `data_err_o`  out  1  access outside the window, registered
- `sram_addr_o`  out  12  line index
- `sram_cs_o`  out  8  word selects; bit k = word k of the line
- `sram_we_o`  out  1  SRAM write
- `sram_be_o`  out  4  SRAM byte enables
- `sram_din_o`  out  32  SRAM write data
- `sram_dout_i`  in  256  SRAM line data; word k is in bits [32*(7-k)+31 : 32*(7-k)]

## Operation
- Address decode:
  - In range: `data_addr_i[31:17] == BASE_ADDR[31:17]`.
  - Line index: `addr[16:5]`.
  - Word index: `addr[4:2]`.
  - `addr[1:0]` is ignored.
- Line buffer: 256-bit data, 12-bit tag, valid bit. Valid resets to 0.
- States: IDLE, FILL.
- In IDLE, `data_gnt_o = data_req_i`. Action for a granted request:
  - Out of range: no SRAM access. Next cycle: rvalid=1, err=1, rdata=0.
  - Write: `sram_cs_o` is the one-hot of the word index, `sram_we_o=1`, `be` and `din` pass through. If the buffer holds that line (hit), the enabled bytes are merged into the buffer at the same edge. Next cycle: rvalid=1, err=0, rdata=0.
  - Read hit: no SRAM access. Next cycle: rvalid=1, rdata is the buffer word.
  - Read miss: `sram_cs_o=8'hFF`, `sram_we_o=0`, `sram_addr_o` = line index. Latch the tag and word index, then go to FILL.
- In FILL, `data_gnt_o=0` and all SRAM outputs are 0.
  - At the FILL edge, capture `sram_dout_i` into the buffer, set tag and valid, and register rvalid=1 with the selected word taken from `sram_dout_i`.
  - Then return to IDLE.
- When not granted, SRAM outputs are 0: `cs=0`, `we=0`, `be=0`, `din=0`, `addr=0`.
- Write followed by a read miss to the same address reads the new data, because the SRAM write commits at the grant edge.

## Timing
- Reset values: state=IDLE, valid=0, tag=0, buffer=0, `data_rvalid_o=0`, `data_rdata_o=0`, `data_err_o=0`. SRAM outputs are 0 while `rst_n=0` (no grant).
- Grant cycle N. Response latency:
  - Hit, write, error: rvalid at N+1.
  - Read miss: rvalid at N+2. Next grant possible at N+2.
- rvalid is a one-cycle pulse per grant. Exactly one response per grant; responses come in grant order.
- Back-to-back hits, writes or errors: one grant per cycle, full throughput.
- Reset asserted mid-FILL: no response is produced. The buffer stays invalid.

## Structure
- Package `zeroriscy_d_pkg` holds:
  - state enum {IDLE, FILL}
  - `LINE_WORDS=8`, `LINE_BITS=256`, `LINE_IDX_W=12`
  - a function mapping word index k to its `sram_dout_i` lane, bits [32*(7-k)+31 : 32*(7-k)]
- Sub-module `zeroriscy_d_linebuf` holds the data, tag and valid registers. It has:
  - a full-line load port
  - a byte-masked single-word write port
  - a hit compare
  - a word read mux

## Test plan
- Reset: hold `rst_n=0` with `data_req_i=1` -> `gnt=0`, all outputs 0. Release -> first request granted.
- Write then read miss: write 32'h1122_3344 to BASE+0x24.
  - Expect `sram_addr_o=1`, `cs=8'b0000_0010`, `we=1`, rvalid at N+1.
  - Then read BASE+0x24 -> `cs=8'hFF`, `addr=1`, `gnt` low the following cycle, rvalid 2 cycles after grant with rdata 32'h1122_3344.
- Read hit: after that fill, read BASE+0x20 then BASE+0x3C back-to-back -> `cs=0` both cycles, two rvalids on consecutive cycles with the words held in lanes [255:224] and [31:0].
- Byte write hit: write `be=4'b0100`, data 32'h00AA_0000 to BASE+0x24, then read it -> `cs=8'b0000_0010` with `be=4'b0100` on the write; read is a hit returning 32'h11AA_3344.
- Out of range: read BASE+0x2_0000 -> gnt, `cs=0`, rvalid with `err=1`, `rdata=0`.
- Reset mid-FILL: drop `rst_n` in the FILL cycle -> no rvalid; a following read of the same line misses (`cs=8'hFF`).
